// File: rtl/ads41_tx_pkg.sv
// Shared definitions for the ADS41 DDR-LVDS transmitter emulator:
// source-mode encodings, FSM states, PRBS15 generator constants and
// the default training word.
package ads41_tx_pkg;

  typedef enum logic [2:0] {
    MODE_USER   = 3'd0,
    MODE_RAMP   = 3'd1,
    MODE_CONST  = 3'd2,
    MODE_TOGGLE = 3'd3,
    MODE_PRBS   = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // PRBS15, x^15 + x^14 + 1, shifted towards the MSB with the new bit at bit 0.
  localparam int                  PRBS_LEN    = 15;
  localparam int                  PRBS_TAP_HI = 14;
  localparam int                  PRBS_TAP_LO = 13;
  localparam logic [PRBS_LEN-1:0] PRBS_SEED   = '1;

  localparam logic [11:0] DEFAULT_TRAIN_PATTERN = 12'hA5C;

  function automatic logic [PRBS_LEN-1:0] prbs15_step(input logic [PRBS_LEN-1:0] s);
    return {s[PRBS_LEN-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/ads41_tx_oddr_lane.sv
// One DDR output lane: an ODDR (both halves captured on the rising edge,
// "same edge" style) followed by a differential output buffer.
// Ports:
//   clk, rst  - line clock, synchronous active-high reset
//   rise      - value driven while clk is high
//   fall      - value driven while clk is low
//   p, n      - differential pad pair
module ads41_tx_oddr_lane (
  input  logic clk,
  input  logic rst,
  input  logic rise,
  input  logic fall,
  output logic p,
  output logic n
);

  logic rise_reg;
  logic fall_reg;
  logic q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= rise;
      fall_reg <= fall;
    end
  end

  // Behavioural DDR output mux: the clock itself selects the half.
  assign q = clk ? rise_reg : fall_reg;
  assign p = q;
  assign n = ~q;

endmodule

// File: rtl/ads41_tx_emulator.sv
// ADS41 DDR-LVDS transmitter emulator. Produces the converter's pin-level
// stream (half-width DDR data, forwarded clock, overrange) from a user
// stream or built-in pattern generators, preceded by a training burst.
// Ports:
//   clk, rst           - sample/line clock, synchronous active-high reset
//   enable             - 1 = train then run, 0 = idle
//   mode               - 0 user, 1 ramp, 2 const, 3 toggle, 4 PRBS15, 5-7 const
//   const_val          - constant word for mode 2/5/6/7
//   s_data/s_ovr/s_valid/s_ready - user sample stream (valid/ready)
//   training           - high while the training burst is being generated
//   underflow_cnt      - saturating count of starved user-mode cycles
//   clear_underflow    - synchronous clear, wins over an increment
//   dclk_p/dclk_n      - forwarded DDR clock
//   d_p/d_n            - DDR data lanes (bit 2k on clock high, 2k+1 on low)
//   ovr                - overrange, single-ended
module ads41_tx_emulator
  import ads41_tx_pkg::*;
#(
  parameter int               NBITS         = 12,
  parameter int               TRAIN_CYCLES  = 64,
  parameter logic [NBITS-1:0] TRAIN_PATTERN = NBITS'(DEFAULT_TRAIN_PATTERN),
  parameter int               UF_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [2:0]           mode,
  input  logic [NBITS-1:0]     const_val,
  input  logic [NBITS-1:0]     s_data,
  input  logic                 s_ovr,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 training,
  output logic [UF_WIDTH-1:0]  underflow_cnt,
  input  logic                 clear_underflow,
  output logic                 dclk_p,
  output logic                 dclk_n,
  output logic [NBITS/2-1:0]   d_p,
  output logic [NBITS/2-1:0]   d_n,
  output logic                 ovr
);

  localparam int             LANES      = NBITS / 2;
  localparam int             TCW        = $clog2(TRAIN_CYCLES);
  localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [TCW-1:0]      train_cnt_reg;
  logic [NBITS-1:0]    ramp_reg;
  logic [PRBS_LEN-1:0] prbs_reg;
  logic [NBITS-1:0]    sample_reg, sample_next;
  logic                ovr_reg, ovr_next;
  logic                clk_en_reg, clk_en_next;
  logic                ovr_pin_reg;
  logic [UF_WIDTH-1:0] underflow_reg;
  logic                underflow_inc;
  logic [NBITS-1:0]    alt_word;

  // Alternating-bit word with the MSB side set: 0xAAA for 12 bits.
  generate
    for (genvar gi = 0; gi < NBITS; gi++) begin : g_alt
      assign alt_word[gi] = 1'(gi % 2);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (enable) state_next = ST_TRAIN;
      ST_TRAIN: begin
        if (!enable)                       state_next = ST_IDLE;
        else if (train_cnt_reg == TRAIN_LAST) state_next = ST_RUN;
      end
      ST_RUN:   if (!enable) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Source mux. Dropping enable forces a zero sample and gated clock in the
  // same cycle, ahead of the state register catching up.
  always_comb begin
    s_ready       = 1'b0;
    sample_next   = '0;
    ovr_next      = 1'b0;
    clk_en_next   = 1'b0;
    underflow_inc = 1'b0;
    if (enable) begin
      case (state_reg)
        ST_TRAIN: begin
          clk_en_next = 1'b1;
          sample_next = train_cnt_reg[0] ? ~TRAIN_PATTERN : TRAIN_PATTERN;
        end
        ST_RUN: begin
          clk_en_next = 1'b1;
          case (mode)
            MODE_USER: begin
              s_ready = 1'b1;
              if (s_valid) begin
                sample_next = s_data;
                ovr_next    = s_ovr;
              end else begin
                // Starved: hold the word currently in flight.
                sample_next   = sample_reg;
                underflow_inc = 1'b1;
              end
            end
            MODE_RAMP:   sample_next = ramp_reg;
            MODE_TOGGLE: sample_next = ramp_reg[0] ? ~alt_word : alt_word;
            MODE_PRBS:   sample_next = NBITS'(prbs_reg);
            default:     sample_next = const_val;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      train_cnt_reg <= '0;
      ramp_reg      <= '0;
      prbs_reg      <= PRBS_SEED;
      sample_reg    <= '0;
      ovr_reg       <= 1'b0;
      clk_en_reg    <= 1'b0;
      ovr_pin_reg   <= 1'b0;
      underflow_reg <= '0;
    end else begin
      state_reg     <= state_next;
      train_cnt_reg <= (state_reg == ST_TRAIN && state_next == ST_TRAIN)
                       ? train_cnt_reg + TCW'(1) : '0;
      // Generators hold their start value outside RUN so every RUN entry
      // begins at ramp 0 / PRBS seed; ramp bit 0 also phases the toggle.
      ramp_reg      <= (state_reg == ST_RUN) ? ramp_reg + NBITS'(1) : '0;
      prbs_reg      <= (state_reg == ST_RUN) ? prbs15_step(prbs_reg) : PRBS_SEED;
      sample_reg    <= sample_next;
      ovr_reg       <= ovr_next;
      clk_en_reg    <= clk_en_next;
      // ODDR with identical halves reduces to a plain register.
      ovr_pin_reg   <= ovr_reg;
      if (clear_underflow)
        underflow_reg <= '0;
      else if (underflow_inc && underflow_reg != '1)
        underflow_reg <= underflow_reg + UF_WIDTH'(1);
    end
  end

  assign training      = (state_reg == ST_TRAIN);
  assign underflow_cnt = underflow_reg;
  assign ovr           = ovr_pin_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      ads41_tx_oddr_lane u_lane (
        .clk  (clk),
        .rst  (rst),
        .rise (sample_reg[2*gi]),
        .fall (sample_reg[2*gi+1]),
        .p    (d_p[gi]),
        .n    (d_n[gi])
      );
    end
  endgenerate

  // Forwarded clock: D1=1, D2=0 while running, gated low otherwise.
  ads41_tx_oddr_lane u_dclk (
    .clk  (clk),
    .rst  (rst),
    .rise (clk_en_reg),
    .fall (1'b0),
    .p    (dclk_p),
    .n    (dclk_n)
  );

endmodule

// File: tb/tb_ads41_tx_emulator.sv
module tb_ads41_tx_emulator;

  localparam int NB = 12;
  localparam int LN = NB / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [2:0]    mode;
  logic [NB-1:0] const_val;
  logic [NB-1:0] s_data;
  logic          s_ovr;
  logic          s_valid;
  logic          s_ready;
  logic          training;
  logic [15:0]   underflow_cnt;
  logic          clear_underflow;
  logic          dclk_p, dclk_n;
  logic [LN-1:0] d_p, d_n;
  logic          ovr;

  ads41_tx_emulator #(
    .NBITS(NB), .TRAIN_CYCLES(64), .TRAIN_PATTERN(12'hA5C), .UF_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .const_val(const_val),
    .s_data(s_data), .s_ovr(s_ovr), .s_valid(s_valid), .s_ready(s_ready),
    .training(training), .underflow_cnt(underflow_cnt),
    .clear_underflow(clear_underflow), .dclk_p(dclk_p), .dclk_n(dclk_n),
    .d_p(d_p), .d_n(d_n), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int pin_err = 0;

  // Pin capture of one line-clock cycle, decoded like the receiver.
  logic [NB-1:0] pw;
  logic          po, pck_hi, pck_lo, ptrain;
  logic [NB-1:0] expw;
  logic          h [0:63];

  typedef struct {
    logic [2:0]  m;
    logic        v;
    logic [11:0] d;
    logic        o;
    logic [11:0] cv;
    logic        clr;
    logic [11:0] ew;
    logic        eo;
    logic        er;
    logic [15:0] eu;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
    ptrain = training;
    po     = ovr;
    pck_hi = dclk_p;
    if (d_n !== ~d_p || dclk_n !== ~dclk_p) pin_err++;
    for (int k = 0; k < LN; k++) pw[2*k] = d_p[k];
    @(negedge clk); #1;
    pck_lo = dclk_p;
    if (d_n !== ~d_p || dclk_n !== ~dclk_p || ovr !== po) pin_err++;
    for (int k = 0; k < LN; k++) pw[2*k+1] = d_p[k];
  endtask

  task automatic drive(input logic [2:0] m, input logic v, input logic [11:0] d,
                       input logic o, input logic [11:0] cv, input logic clr);
    mode = m; s_valid = v; s_data = d; s_ovr = o; const_val = cv; clear_underflow = clr;
  endtask

  // Enable was raised just before the first edge; covers steps 0..65.
  task automatic do_train(input string tag);
    int tcount = 0;
    logic [11:0] tw;
    for (int j = 0; j < 66; j++) begin
      step();
      if (ptrain) tcount++;
      chk($sformatf("%s_training_%0d", tag, j), 32'(ptrain), 32'(j < 64));
      if (j >= 2) begin
        tw = (j % 2 == 0) ? 12'hA5C : 12'h5A3;
        chk($sformatf("%s_trainword_%0d", tag, j), {17'd0, pck_hi, pck_lo, po, pw},
            {17'd0, 2'b10, 1'b0, tw});
      end else begin
        chk($sformatf("%s_gated_%0d", tag, j), {17'd0, pck_hi, pck_lo, po, pw}, 32'd0);
      end
    end
    chk($sformatf("%s_train_len", tag), 32'(tcount), 32'd64);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ramp_err;
    logic [11:0] rexp;

    tbl[0]  = '{3'd0, 1'b1, 12'h123, 1'b1, 12'h000, 1'b0, 12'h123, 1'b1, 1'b1, 16'd0};
    tbl[1]  = '{3'd0, 1'b0, 12'h456, 1'b1, 12'h000, 1'b0, 12'h123, 1'b0, 1'b1, 16'd1};
    tbl[2]  = '{3'd0, 1'b1, 12'h456, 1'b0, 12'h000, 1'b0, 12'h456, 1'b0, 1'b1, 16'd1};
    tbl[3]  = '{3'd2, 1'b1, 12'hDEF, 1'b1, 12'h3C3, 1'b0, 12'h3C3, 1'b0, 1'b0, 16'd1};
    tbl[4]  = '{3'd5, 1'b0, 12'h000, 1'b0, 12'h0F0, 1'b0, 12'h0F0, 1'b0, 1'b0, 16'd1};
    tbl[5]  = '{3'd7, 1'b1, 12'h111, 1'b1, 12'hFFF, 1'b0, 12'hFFF, 1'b0, 1'b0, 16'd1};
    tbl[6]  = '{3'd0, 1'b1, 12'hABC, 1'b0, 12'h000, 1'b0, 12'hABC, 1'b0, 1'b1, 16'd1};
    tbl[7]  = '{3'd0, 1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 12'hABC, 1'b0, 1'b1, 16'd2};
    tbl[8]  = '{3'd0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 12'hABC, 1'b0, 1'b1, 16'd3};
    tbl[9]  = '{3'd6, 1'b0, 12'h000, 1'b0, 12'h001, 1'b0, 12'h001, 1'b0, 1'b0, 16'd3};
    tbl[10] = '{3'd0, 1'b1, 12'h7E5, 1'b1, 12'h000, 1'b0, 12'h7E5, 1'b1, 1'b1, 16'd3};
    tbl[11] = '{3'd0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 12'h7E5, 1'b0, 1'b1, 16'd0};
    tbl[12] = '{3'd0, 1'b1, 12'h800, 1'b0, 12'h000, 1'b0, 12'h800, 1'b0, 1'b1, 16'd0};

    for (int m = 0; m < 15; m++) h[m] = 1'b1;
    for (int m = 15; m < 64; m++) h[m] = h[m-15] ^ h[m-14];

    // Reset state
    rst = 1'b1; enable = 1'b0;
    drive(3'd0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    repeat (3) step();
    chk("rst_training", 32'(ptrain), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_uf", 32'(underflow_cnt), 32'd0);
    chk("rst_pins", {17'd0, pck_hi, pck_lo, po, pw}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_pins", {17'd0, pck_hi, pck_lo, po, pw}, 32'd0);

    // Training then ramp, including the wrap
    enable = 1'b1;
    drive(3'd1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    do_train("ramp");
    chk("ready_mode1", 32'(s_ready), 32'd0);
    ramp_err = 0;
    for (int s = 66; s < 66 + 4098; s++) begin
      step();
      rexp = 12'(s - 66);
      if (pw !== rexp || {pck_hi, pck_lo} !== 2'b10 || po !== 1'b0) ramp_err++;
      if (s < 69) chk($sformatf("ramp_first_%0d", s - 66), 32'(pw), 32'(rexp));
      if (s - 66 == 4095) chk("ramp_fff", 32'(pw), 32'hFFF);
      if (s - 66 == 4096) chk("ramp_wrap", 32'(pw), 32'h000);
    end
    chk("ramp_seq_errors", 32'(ramp_err), 32'd0);

    // Table-driven user/const vectors; pins lag inputs by one step here
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        drive(tbl[i].m, tbl[i].v, tbl[i].d, tbl[i].o, tbl[i].cv, tbl[i].clr);
        #1;
        chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(tbl[i].er));
      end
      step();
      if (i < NV) chk($sformatf("vec%0d_uf", i), 32'(underflow_cnt), 32'(tbl[i].eu));
      if (i > 0) chk($sformatf("vec%0d_pins", i - 1), {19'd0, po, pw},
                     {19'd0, tbl[i-1].eo, tbl[i-1].ew});
    end

    // Saturation and clear priority
    drive(3'd0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    chk("uf_saturate", 32'(underflow_cnt), 32'hFFFF);
    clear_underflow = 1'b1;
    @(posedge clk); #1;
    chk("uf_clear_vs_starve", 32'(underflow_cnt), 32'd0);
    clear_underflow = 1'b0;
    @(posedge clk); #1;
    chk("uf_after_clear", 32'(underflow_cnt), 32'd1);

    // Enable drop mid-RUN
    drive(3'd0, 1'b1, 12'h2D1, 1'b0, 12'h000, 1'b0);
    #1;
    chk("ready_run", 32'(s_ready), 32'd1);
    enable = 1'b0;
    #1;
    chk("ready_drop", 32'(s_ready), 32'd0);
    step();
    chk("training_off", 32'(ptrain), 32'd0);
    step();
    chk("drop_pins", {17'd0, pck_hi, pck_lo, po, pw}, 32'd0);

    // Retrain into PRBS15
    enable = 1'b1;
    drive(3'd4, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    do_train("prbs");
    for (int t = 0; t < 16; t++) begin
      step();
      for (int k = 0; k < NB; k++) expw[k] = h[14 + t - k];
      chk($sformatf("prbs_word_%0d", t), {18'd0, pck_hi, pck_lo, pw}, {18'd0, 2'b10, expw});
    end

    // Reset pulse mid-TRAIN, then retrain into toggle
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    drive(3'd3, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    repeat (10) step();
    chk("midtrain_training", 32'(ptrain), 32'd1);
    rst = 1'b1;
    step();
    chk("rst2_training", 32'(ptrain), 32'd0);
    chk("rst2_ready", 32'(s_ready), 32'd0);
    chk("rst2_uf", 32'(underflow_cnt), 32'd0);
    chk("rst2_pins", {17'd0, pck_hi, pck_lo, po, pw}, 32'd0);
    rst = 1'b0;
    do_train("toggle");
    for (int t = 0; t < 4; t++) begin
      step();
      expw = (t % 2 == 0) ? 12'hAAA : 12'h555;
      chk($sformatf("toggle_word_%0d", t), {18'd0, pck_hi, pck_lo, pw}, {18'd0, 2'b10, expw});
    end

    chk("pin_level_errors", 32'(pin_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ads41_tx_emulator.md
# ads41_tx_emulator

Source-synchronous transmitter that drives the ADS41 DDR-LVDS format: half-width parallel data, forwarded line clock and overrange. Produces the same pin-level stream the ADS41 receiver path captures. Used for loopback and board bring-up: one FPGA emulates the ADC so the capture side, IDELAY calibration and clocking can be exercised without a converter. Sits between user or pattern logic on `clk` and the LVDS output buffers.

## Interface
Parameters:
- `NBITS`, 12, sample width; must be even; lanes = NBITS/2
- `TRAIN_CYCLES`, 64, length of training burst in `clk` cycles, ≥2
- `TRAIN_PATTERN`, 12'hA5C, training word; alternates with its bitwise inverse
- `UF_WIDTH`, 16, underflow counter width

Ports:
- `clk` in 1: sample clock; one sample per cycle; also the forwarded line clock
- `rst` in 1: synchronous, active-high reset
- `enable` in 1: level; 1 = train then run, 0 = idle
- `mode` in 3: 0 user stream, 1 ramp, 2 constant, 3 toggle, 4 PRBS15; 5–7 behave as 2
- `const_val` in NBITS: word for mode 2
- `s_data` in NBITS: user sample
- `s_ovr` in 1: user overrange flag
- `s_valid` in 1: user sample valid
- `s_ready` out 1: sample accepted when `s_valid & s_ready`
- `training` out 1: high while in TRAIN
- `underflow_cnt` out UF_WIDTH: saturating count of starved cycles
- `clear_underflow` in 1: synchronous clear of `underflow_cnt`
- `dclk_p`/`dclk_n` out 1: forwarded DDR clock
- `d_p`/`d_n` out NBITS/2: DDR data lanes
- `ovr` out 1: overrange, single-ended

## Operation
- FSM states are IDLE, TRAIN and RUN. Reset puts the FSM in IDLE.
- IDLE → TRAIN when `enable`=1. TRAIN → RUN after exactly TRAIN_CYCLES cycles. Any state → IDLE on the cycle after `enable`=0. `rst` overrides everything.
- IDLE behaviour:
  - sample = 0, `ovr`=0.
  - Forwarded clock is gated low (both DDR halves 0).
- TRAIN behaviour:
  - The clock runs.
  - Sample alternates TRAIN_PATTERN and ~TRAIN_PATTERN, starting with TRAIN_PATTERN.
  - `ovr`=0 and `training`=1.
- RUN behaviour: sample source is selected by `mode` each cycle. A mode change takes effect on the next sample and does not retrain.
  - Mode 0: `s_ready`=1. An accepted sample is sent with `s_ovr`. On a starved cycle (`s_valid`=0) the last sent word is repeated, `ovr`=0 and `underflow_cnt` is incremented (saturating at all-ones).
  - Mode 1: counter cleared to 0 on RUN entry, +1 per cycle, wraps 2^NBITS−1 → 0.
  - Modes 2, 5, 6, 7: `const_val`.
  - Mode 3: alternates 0xAAA then 0x555 (generally the alternating-bit pattern for NBITS), starting with 0xAAA.
  - Mode 4: PRBS15 with polynomial x^15+x^14+1 and seed all-ones at RUN entry. Advances one step per cycle. Output is state[NBITS-1:0].
  - `ovr`=0 in all modes except 0.
- `s_ready`=0 outside RUN and in modes other than 0.
- `underflow_cnt` counts only in RUN with mode 0.
- `clear_underflow` takes priority over an increment in the same cycle.
- Lane mapping: lane k carries sample bit 2k during clock-high and bit 2k+1 during clock-low.
- The forwarded clock is a DDR register with D1=1, D2=0. Data and clock are edge-aligned; the receiver centres with IDELAY.

## Timing
- Reset values:
  - `s_ready`=0, `training`=0, `underflow_cnt`=0.
  - Pins: data 0, clock low, `ovr`=0.
- Latency: a sample accepted or selected at rising edge N is registered in `sample_q` at edge N. It is launched on the pins from edge N+1 (even bits) through the following falling edge (odd bits). This is a fixed 2-cycle latency and applies to every source.
- `training` asserts the cycle after IDLE → TRAIN and deasserts on the first RUN cycle.
- The first RUN sample leaves the pins 2 cycles after `training` falls.
- If `enable` drops mid-TRAIN or mid-RUN:
  - The next sample is 0 and `s_ready` drops the same cycle.
  - Re-enabling always retrains and reseeds the ramp and PRBS.
- `rst` mid-operation: all state returns to reset values on the next edge, including in-flight pipeline registers.

## Structure
- Package `ads41_tx_pkg` holds:
  - mode encodings (MODE_USER..MODE_PRBS)
  - FSM state enum
  - PRBS15 taps and seed
  - default TRAIN_PATTERN
- Sub-module `ads41_tx_oddr_lane`: one ODDR plus OBUFDS with `rise`/`fall` inputs. It is instantiated NBITS/2 times for data and once for the clock. `ovr` uses ODDR plus OBUF with both halves equal.
- Top level holds the FSM, source mux, generators, handshake and counter.

## Test plan
- Reset, then `enable`=1, mode 1 → `training` high for exactly 64 cycles. Pins show 0xA5C/0x5A3 alternating, then a ramp 0,1,2… starting 2 cycles after `training` falls.
- Mode 1 run ≥4100 cycles → sample 0xFFF is followed by 0x000.
- Mode 0, `s_valid` toggling 1,0,1 with data 0x123, 0x456, `s_ovr`=1 on the first → pins show 0x123 (`ovr`=1), 0x123 (`ovr`=0), 0x456. `underflow_cnt`=1.
- Hold `s_valid`=0 for 70000 cycles → `underflow_cnt` stays at 0xFFFF. Asserting `clear_underflow` together with a starve gives 0.
- Mode 4 → first 16 output words match a reference PRBS15 model seeded with all-ones. Lane decoding (bit 2k on high, 2k+1 on low) matches the receiver capture model.
- `enable`=0 mid-RUN, then 1 → `s_ready` falls the same cycle, the clock gates low, zeros are sent, and a full 64-cycle retrain runs. Pulsing `rst` mid-TRAIN returns all outputs to reset values on the next edge.
